// File: rtl/vc_buffer_unit_if.sv
// vc_buffer_unit_if: four-phase req/ack flit link carrying a VC tag
interface vc_buffer_unit_if #(
    parameter int DATA_WIDTH = 18,
    parameter int VCW = 1
);
    logic req;
    logic [VCW-1:0] vc;
    logic [DATA_WIDTH-1:0] data;
    logic ack;
    modport master(output req, vc, data, input ack);
    modport slave(input req, vc, data, output ack);
endinterface

// File: rtl/vc_buffer_unit.sv
// vc_buffer_unit: multi-VC router input buffer with per-VC packet FSM, allocator requests and credit return
module vc_buffer_unit #(
    parameter int DATA_WIDTH = 18,
    parameter int NUM_VC = 2,
    parameter int VC_DEPTH = 4,
    parameter int MAX_PACKET_SIZE = 64
) (
    input  logic clk,
    input  logic rst,
    vc_buffer_unit_if.slave up,
    vc_buffer_unit_if.master down,
    output logic [NUM_VC-1:0] sa_req,
    input  logic [NUM_VC-1:0] sa_grant,
    output logic [NUM_VC-1:0] credit_out,
    output logic [2:0] err
);
    localparam int VCW = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
    localparam int PW = $clog2(VC_DEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(MAX_PACKET_SIZE) + 1;
    typedef enum logic [1:0] {IDLE, WAIT_GRANT, ACTIVE} state_t;
    logic [NUM_VC-1:0] act, full, empty, wr_v, hs_pop, flush, ovf, grant_ok;
    logic [DATA_WIDTH-1:0] front [NUM_VC];
    logic [VCW-1:0] av;
    logic wr, hs, grant_bad;
    assign hs = down.req && down.ack;
    assign wr = up.req && !up.ack && int'(up.vc) < NUM_VC && !full[up.vc];
    assign grant_bad = |sa_grant && (!$onehot(sa_grant) || |act || |(sa_grant & ~sa_req));
    assign credit_out = hs_pop | flush;
    always_comb begin
        av = '0;
        for (int i = 0; i < NUM_VC; i++)
            if (act[i]) av = VCW'(i);
    end
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        state_t st, st_nx;
        logic [DATA_WIDTH-1:0] mem [VC_DEPTH];
        logic [PW-1:0] rd_ptr, wr_ptr;
        logic [CW-1:0] cnt;
        logic [KW-1:0] pkt;
        logic sa_q;
        logic [1:0] ftype;
        assign front[v] = mem[rd_ptr];
        assign ftype = front[v][DATA_WIDTH-1 -: 2];
        assign full[v] = cnt == CW'(VC_DEPTH);
        assign empty[v] = cnt == '0;
        assign act[v] = st == ACTIVE;
        assign wr_v[v] = wr && up.vc == VCW'(v);
        assign hs_pop[v] = hs && down.vc == VCW'(v);
        // a non-head flit at the front of an idle VC is an orphan; discard it
        assign flush[v] = st == IDLE && !empty[v] && !ftype[0];
        assign ovf[v] = hs_pop[v] && ftype == 2'b00 && pkt >= KW'(MAX_PACKET_SIZE - 2);
        assign grant_ok[v] = sa_grant[v] && sa_q && $onehot(sa_grant) && !(|act);
        assign sa_req[v] = sa_q;
        always_comb begin
            st_nx = st;
            if (st == IDLE && !empty[v] && ftype[0]) st_nx = WAIT_GRANT;
            if (st == WAIT_GRANT && grant_ok[v]) st_nx = ACTIVE;
            if (st == ACTIVE && hs_pop[v] && (ftype[1] || ovf[v])) st_nx = IDLE;
        end
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st <= IDLE;
                sa_q <= 1'b0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt <= '0;
                pkt <= '0;
            end else begin
                st <= st_nx;
                sa_q <= st_nx == WAIT_GRANT;
                if (wr_v[v]) wr_ptr <= wr_ptr + 1'b1;
                if (credit_out[v]) rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CW'(wr_v[v]) - CW'(credit_out[v]);
                if (hs_pop[v]) pkt <= ftype[0] ? KW'(1) : pkt + 1'b1;
            end
        end
        always_ff @(posedge clk)
            if (wr_v[v]) mem[wr_ptr] <= up.data;
    end
    // output register holds the flit stable while req is up; one idle cycle between flits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up.ack <= 1'b0;
            down.req <= 1'b0;
            down.vc <= '0;
            down.data <= '0;
            err <= '0;
        end else begin
            up.ack <= wr;
            err <= err | {grant_bad, |ovf, |flush};
            if (hs) down.req <= 1'b0;
            else if (!down.req && |act && !empty[av]) begin
                down.req <= 1'b1;
                down.vc <= av;
                down.data <= front[av];
            end
        end
    end
endmodule

// File: tb/tb_vc_buffer_unit.sv
// tb_vc_buffer_unit: scoreboard bench; expected flits are queued at stimulus time and checked by an output monitor
module tb_vc_buffer_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] sa_req, sa_grant, credit_out;
    logic [1:0] man_grant = 2'b00;
    logic auto_grant = 1'b0;
    logic [2:0] err;
    int checks = 0, errors = 0, ack_cnt = 0, a0 = 0;
    int cred [2];
    logic [31:0] exp_q [$];
    logic [31:0] e;
    vc_buffer_unit_if #(.DATA_WIDTH(18), .VCW(1)) up ();
    vc_buffer_unit_if #(.DATA_WIDTH(18), .VCW(1)) down ();
    vc_buffer_unit #(.DATA_WIDTH(18), .NUM_VC(2), .VC_DEPTH(4), .MAX_PACKET_SIZE(4)) dut (
        .clk(clk), .rst(rst), .up(up), .down(down), .sa_req(sa_req),
        .sa_grant(sa_grant), .credit_out(credit_out), .err(err)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic expect_flit(input logic vc, input logic [17:0] d);
        exp_q.push_back({13'd0, vc, d});
    endtask

    task automatic send(input logic vc, input logic [17:0] d);
        int n = 0;
        up.vc = vc;
        up.data = d;
        up.req = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (up.ack !== 1'b1 && n < 200);
        chk("in_ack", 32'(up.ack), 32'd1);
        up.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic grant(input logic [1:0] g);
        man_grant = g;
        @(posedge clk); #1;
        man_grant = 2'b00;
    endtask

    task automatic wait_sa(input logic [1:0] ev);
        int n = 0;
        while (sa_req !== ev && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sa_req", 32'(sa_req), 32'(ev));
    endtask

    task automatic wait_q(input int k);
        int n = 0;
        while (exp_q.size() > k && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'(k));
    endtask

    task automatic settle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // downstream: one-cycle ack per req
    initial begin
        down.ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            down.ack = down.req === 1'b1 && !down.ack;
        end
    end

    // allocator: manual grants take priority, else optional one-cycle auto grant to the lowest requester
    initial begin
        sa_grant = 2'b00;
        forever begin
            @(posedge clk); #2;
            if (man_grant != 2'b00) sa_grant = man_grant;
            else if (auto_grant && sa_grant == 2'b00 && sa_req != 2'b00) sa_grant = sa_req[0] ? 2'b01 : 2'b10;
            else sa_grant = 2'b00;
        end
    end

    initial begin
        cred[0] = 0;
        cred[1] = 0;
        forever begin
            @(negedge clk);
            if (up.ack === 1'b1) ack_cnt++;
            for (int v = 0; v < 2; v++)
                if (credit_out[v] === 1'b1) cred[v]++;
            if (down.req === 1'b1 && down.ack === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_flit", {13'd0, down.vc, down.data}, 32'hffffffff);
                else begin
                    e = exp_q.pop_front();
                    chk("out_vc", 32'(down.vc), 32'(e[18]));
                    chk("out_data", 32'(down.data), 32'(e[17:0]));
                    chk("credit_at_ack", 32'(credit_out), 32'(2'b01 << e[18]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        up.req = 1'b0;
        up.vc = 1'b0;
        up.data = '0;
        #17 rst = 1'b1;
        #1;
        chk("rst_ctrl", 32'({up.ack, down.req, sa_req, credit_out, err}), 32'd0);
        chk("rst_data", 32'({down.vc, down.data}), 32'd0);
        settle(1);
        // single head+tail flit on VC0
        send(1'b0, 18'h3C15B);
        wait_sa(2'b01);
        expect_flit(1'b0, 18'h3C15B);
        grant(2'b01);
        chk("sa_drop0", 32'(sa_req), 32'd0);
        wait_q(0);
        settle(2);
        chk("cred0_t1", 32'(cred[0]), 32'd1);
        chk("idle0", 32'(sa_req), 32'd0);
        chk("err_t1", 32'(err), 32'd0);
        // 3-flit packet on VC1
        send(1'b1, 18'h10001);
        send(1'b1, 18'h00002);
        send(1'b1, 18'h20003);
        expect_flit(1'b1, 18'h10001);
        expect_flit(1'b1, 18'h00002);
        expect_flit(1'b1, 18'h20003);
        wait_sa(2'b10);
        grant(2'b10);
        chk("sa_drop1", 32'(sa_req), 32'd0);
        wait_q(0);
        settle(2);
        chk("cred1_t2", 32'(cred[1]), 32'd3);
        chk("err_t2", 32'(err), 32'd0);
        // full VC0 holds off the fifth flit until a pop
        send(1'b0, 18'h10011);
        send(1'b0, 18'h00012);
        send(1'b0, 18'h20013);
        send(1'b0, 18'h30014);
        wait_sa(2'b01);
        a0 = ack_cnt;
        expect_flit(1'b0, 18'h10011);
        expect_flit(1'b0, 18'h00012);
        expect_flit(1'b0, 18'h20013);
        expect_flit(1'b0, 18'h30014);
        expect_flit(1'b0, 18'h30015);
        fork
            send(1'b0, 18'h30015);
            begin
                settle(6);
                chk("full_no_ack", 32'(ack_cnt), 32'(a0));
                auto_grant = 1'b1;
            end
        join
        wait_q(0);
        settle(3);
        auto_grant = 1'b0;
        chk("full_acked", 32'(ack_cnt), 32'(a0 + 1));
        chk("cred0_t3", 32'(cred[0]), 32'd6);
        chk("err_t3", 32'(err), 32'd0);
        // grant to VC1 while VC0 is active is rejected
        send(1'b0, 18'h10021);
        send(1'b0, 18'h20022);
        send(1'b1, 18'h30023);
        expect_flit(1'b0, 18'h10021);
        expect_flit(1'b0, 18'h20022);
        expect_flit(1'b1, 18'h30023);
        wait_sa(2'b11);
        grant(2'b01);
        grant(2'b10);
        chk("err_grant", 32'(err), 32'd4);
        chk("sa_vc1_held", 32'(sa_req), 32'd2);
        wait_q(1);
        settle(2);
        grant(2'b10);
        wait_q(0);
        settle(2);
        chk("cred0_t4", 32'(cred[0]), 32'd8);
        chk("cred1_t4", 32'(cred[1]), 32'd4);
        chk("err_t4", 32'(err), 32'd4);
        // orphan body flit is flushed
        send(1'b0, 18'h00AAA);
        settle(2);
        chk("err_orphan", 32'(err), 32'd5);
        chk("cred0_orphan", 32'(cred[0]), 32'd9);
        chk("no_out_req", 32'(down.req), 32'd0);
        // oversized packet: third pop overflows, rest flushed
        auto_grant = 1'b1;
        expect_flit(1'b0, 18'h10031);
        expect_flit(1'b0, 18'h00032);
        expect_flit(1'b0, 18'h00033);
        send(1'b0, 18'h10031);
        send(1'b0, 18'h00032);
        send(1'b0, 18'h00033);
        send(1'b0, 18'h00034);
        send(1'b0, 18'h00035);
        send(1'b0, 18'h20036);
        wait_q(0);
        settle(4);
        auto_grant = 1'b0;
        chk("err_ovf", 32'(err), 32'd7);
        chk("cred0_ovf", 32'(cred[0]), 32'd15);
        // reset with two flits queued on VC1
        send(1'b1, 18'h10041);
        send(1'b1, 18'h00042);
        wait_sa(2'b10);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({up.ack, down.req, sa_req, credit_out}), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        #2 rst = 1'b1;
        settle(4);
        chk("rst_fifo_empty", 32'(sa_req), 32'd0);
        chk("rst_no_credit", 32'(cred[1]), 32'd4);
        auto_grant = 1'b1;
        expect_flit(1'b0, 18'h3005A);
        send(1'b0, 18'h3005A);
        wait_q(0);
        settle(2);
        auto_grant = 1'b0;
        chk("cred0_post_rst", 32'(cred[0]), 32'd16);
        chk("err_post_rst", 32'(err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
